// File: rtl/hazard_sequencer.sv
// Pipeline hazard control for the 5-stage core: stage-register stall/flush,
// EX operand forwarding, data-memory wait sequencing and performance counters.
module hazard_sequencer #(
    parameter int COUNT_W     = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         Rs1D,
    input  logic [4:0]         Rs2D,
    input  logic [4:0]         Rs1E,
    input  logic [4:0]         Rs2E,
    input  logic [4:0]         RdE,
    input  logic [1:0]         ResultSrcE,
    input  logic               RegWriteE,
    input  logic               PCSrcE,
    input  logic [4:0]         RdM,
    input  logic [4:0]         RdW,
    input  logic               RegWriteM,
    input  logic               RegWriteW,
    input  logic               MemReqM,
    input  logic               MemReadyM,
    output logic               StallF,
    output logic               StallD,
    output logic               StallE,
    output logic               StallM,
    output logic               FlushD,
    output logic               FlushE,
    output logic               FlushW,
    output logic [1:0]         ForwardAE,
    output logic [1:0]         ForwardBE,
    output logic               mem_wait,
    output logic               mem_fault,
    output logic [COUNT_W-1:0] stall_count,
    output logic [COUNT_W-1:0] flush_count
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0]  WAIT_SAT  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              lw_stall;
    logic              mem_stall;
    logic              flush_event;

    assign lw_stall  = RegWriteE && (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_stall = MemReqM && !MemReadyM;
    assign flush_event = PCSrcE && !mem_stall;
    assign mem_wait  = (state == WAIT);

    // M is the younger producer, so it wins over W when both match.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && (RdM != 5'd0) && (RdM == rs))
            return 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!rst) begin
            ForwardAE = fwd_sel(Rs1E);
            ForwardBE = fwd_sel(Rs2E);
        end
    end

    // NOTE: every output gets a default first so no path through the
    // priority chain leaves one unassigned, which would infer a latch.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (mem_stall) state_nxt = WAIT;
            WAIT:    if (MemReadyM) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // Wait counter is held at zero in RUN, so it starts clean on every entry
    // to WAIT; the fault is sticky and does not end the wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            mem_fault <= 1'b0;
        end else if (state == RUN) begin
            wait_cnt <= '0;
        end else begin
            if (wait_cnt != WAIT_SAT)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (wait_cnt == WAIT_LAST)
                mem_fault <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (StallF && (stall_count != CNT_MAX))
                stall_count <= stall_count + COUNT_W'(1);
            if (flush_event && (flush_count != CNT_MAX))
                flush_count <= flush_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: table-driven combinational vectors
// followed by hand-written multi-cycle sequences.
module tb_hazard_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       RegWriteE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;

    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        mem_wait, mem_fault;
    logic [15:0] stall_count, flush_count;

    logic        s_StallF, s_StallD, s_StallE, s_StallM, s_FlushD, s_FlushE, s_FlushW;
    logic [1:0]  s_ForwardAE, s_ForwardBE;
    logic        s_mem_wait, s_mem_fault;
    logic [1:0]  s_stall_count, s_flush_count;

    hazard_sequencer #(.COUNT_W(16), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .RegWriteE(RegWriteE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_wait(mem_wait), .mem_fault(mem_fault),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    hazard_sequencer #(.COUNT_W(2), .MEM_TIMEOUT(64)) dut_sat (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .RegWriteE(RegWriteE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(s_StallF), .StallD(s_StallD), .StallE(s_StallE), .StallM(s_StallM),
        .FlushD(s_FlushD), .FlushE(s_FlushE), .FlushW(s_FlushW),
        .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
        .mem_wait(s_mem_wait), .mem_fault(s_mem_fault),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic [1:0] rsrc;
        logic       regwe, pcsrc;
        logic [4:0] rdm, rdw;
        logic       regwm, regww, memreq, memrdy;
        logic [3:0] es;   // {StallF, StallD, StallE, StallM}
        logic [2:0] ef;   // {FlushD, FlushE, FlushW}
        logic [1:0] ea, eb;
    } vec_t;

    vec_t vecs[16];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t mkv(
        input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde,
        input logic [1:0] rsrc, input logic regwe, pcsrc,
        input logic [4:0] rdm, rdw, input logic regwm, regww, memreq, memrdy,
        input logic [3:0] es, input logic [2:0] ef, input logic [1:0] ea, eb);
        vec_t v;
        v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e; v.rde = rde;
        v.rsrc = rsrc; v.regwe = regwe; v.pcsrc = pcsrc;
        v.rdm = rdm; v.rdw = rdw; v.regwm = regwm; v.regww = regww;
        v.memreq = memreq; v.memrdy = memrdy;
        v.es = es; v.ef = ef; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 2'b00; RegWriteE = 0; PCSrcE = 0;
        RegWriteM = 0; RegWriteW = 0; MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic set_lw(input logic [4:0] rd);
        ResultSrcE = 2'b01; RegWriteE = 1; RdE = rd; Rs2D = 5'd7;
    endtask

    task automatic apply(input vec_t v);
        Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e; RdE = v.rde;
        ResultSrcE = v.rsrc; RegWriteE = v.regwe; PCSrcE = v.pcsrc;
        RdM = v.rdm; RdW = v.rdw; RegWriteM = v.regwm; RegWriteW = v.regww;
        MemReqM = v.memreq; MemReadyM = v.memrdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [3:0] stalls();
        return {StallF, StallD, StallE, StallM};
    endfunction

    function automatic logic [2:0] flushes();
        return {FlushD, FlushE, FlushW};
    endfunction

    initial begin
        //          rs1d rs2d rs1e rs2e rde rsrc we pc  rdm rdw wm ww rq rdy  es       ef      ea     eb
        vecs[0]  = mkv(0, 0, 0, 0, 0, 2'd0, 0, 0,  0, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 2'b00, 2'b00);
        vecs[1]  = mkv(0, 0, 5, 0, 0, 2'd0, 0, 0,  5, 5, 1, 1, 0, 0, 4'b0000, 3'b000, 2'b10, 2'b00);
        vecs[2]  = mkv(0, 0, 5, 0, 0, 2'd0, 0, 0,  0, 5, 1, 1, 0, 0, 4'b0000, 3'b000, 2'b01, 2'b00);
        vecs[3]  = mkv(0, 0, 0, 0, 0, 2'd0, 0, 0,  0, 0, 1, 1, 0, 0, 4'b0000, 3'b000, 2'b00, 2'b00);
        vecs[4]  = mkv(0, 0, 3, 9, 0, 2'd0, 0, 0,  9, 3, 1, 1, 0, 0, 4'b0000, 3'b000, 2'b01, 2'b10);
        vecs[5]  = mkv(0, 0, 0, 9, 0, 2'd0, 0, 0,  9, 9, 0, 1, 0, 0, 4'b0000, 3'b000, 2'b00, 2'b01);
        vecs[6]  = mkv(0, 7, 0, 0, 7, 2'd1, 1, 0,  0, 0, 0, 0, 0, 0, 4'b1100, 3'b010, 2'b00, 2'b00);
        vecs[7]  = mkv(0, 7, 0, 0, 0, 2'd1, 1, 0,  0, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 2'b00, 2'b00);
        vecs[8]  = mkv(7, 0, 0, 0, 7, 2'd0, 1, 0,  0, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 2'b00, 2'b00);
        vecs[9]  = mkv(7, 0, 0, 0, 7, 2'd1, 0, 0,  0, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 2'b00, 2'b00);
        vecs[10] = mkv(0, 0, 0, 0, 0, 2'd0, 0, 1,  0, 0, 0, 0, 0, 0, 4'b0000, 3'b110, 2'b00, 2'b00);
        vecs[11] = mkv(0, 7, 0, 0, 7, 2'd1, 1, 1,  0, 0, 0, 0, 0, 0, 4'b0000, 3'b110, 2'b00, 2'b00);
        vecs[12] = mkv(0, 7, 4, 0, 7, 2'd1, 1, 1,  4, 0, 1, 0, 1, 0, 4'b1111, 3'b001, 2'b10, 2'b00);
        vecs[13] = mkv(0, 7, 0, 0, 7, 2'd1, 1, 0,  0, 0, 0, 0, 1, 1, 4'b1100, 3'b010, 2'b00, 2'b00);
        vecs[14] = mkv(0, 0, 6, 6, 0, 2'd0, 0, 0,  6, 6, 1, 1, 0, 1, 4'b0000, 3'b000, 2'b10, 2'b10);
        vecs[15] = mkv(0, 0, 6, 6, 0, 2'd0, 0, 0,  6, 6, 0, 0, 0, 0, 4'b0000, 3'b000, 2'b00, 2'b00);

        // Reset state, with inputs that would otherwise forward, stall and miss.
        rst = 1'b1;
        set_idle();
        Rs1E = 5; RdM = 5; RegWriteM = 1; MemReqM = 1; PCSrcE = 1;
        set_lw(5'd7);
        repeat (2) @(negedge clk);
        check("rst stalls", 32'(stalls()), 32'h0);
        check("rst flushes", 32'(flushes()), 32'h7);
        check("rst fwdA", 32'(ForwardAE), 32'h0);
        check("rst mem_wait", 32'(mem_wait), 32'h0);
        check("rst mem_fault", 32'(mem_fault), 32'h0);
        check("rst stall_count", 32'(stall_count), 32'h0);
        check("rst flush_count", 32'(flush_count), 32'h0);
        do_reset();

        for (int i = 0; i < 16; i++) begin
            tick();
            apply(vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d stalls", i), 32'(stalls()), 32'(vecs[i].es));
            check($sformatf("vec%0d flushes", i), 32'(flushes()), 32'(vecs[i].ef));
            check($sformatf("vec%0d fwdA", i), 32'(ForwardAE), 32'(vecs[i].ea));
            check($sformatf("vec%0d fwdB", i), 32'(ForwardBE), 32'(vecs[i].eb));
        end

        // Load-use counts one stall cycle, then branch during load-use.
        do_reset();
        tick(); set_lw(5'd7);
        @(negedge clk);
        check("lu stalls", 32'(stalls()), 32'hC);
        check("lu count before", 32'(stall_count), 32'h0);
        tick(); set_lw(5'd0);
        @(negedge clk);
        check("lu rd0 stalls", 32'(stalls()), 32'h0);
        check("lu count after", 32'(stall_count), 32'h1);
        tick(); set_lw(5'd7); PCSrcE = 1;
        @(negedge clk);
        check("br+lu stalls", 32'(stalls()), 32'h0);
        check("br+lu flushes", 32'(flushes()), 32'h6);
        check("br flush_count before", 32'(flush_count), 32'h0);
        tick(); set_idle();
        @(negedge clk);
        check("br flush_count after", 32'(flush_count), 32'h1);
        check("br stall_count held", 32'(stall_count), 32'h1);

        // Three-cycle memory wait, below the timeout.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            tick();
            set_idle();
            MemReqM   = (k <= 4);
            MemReadyM = (k == 4);
            @(negedge clk);
            check($sformatf("mw%0d stalls", k), 32'(stalls()), (k <= 3) ? 32'hF : 32'h0);
            check($sformatf("mw%0d flushW", k), 32'(FlushW), (k <= 3) ? 32'h1 : 32'h0);
            check($sformatf("mw%0d mem_wait", k), 32'(mem_wait), (k >= 2 && k <= 4) ? 32'h1 : 32'h0);
        end
        check("mw stall_count", 32'(stall_count), 32'h3);
        check("mw no fault", 32'(mem_fault), 32'h0);

        // Six miss cycles against MEM_TIMEOUT=4: fault after four WAIT cycles.
        do_reset();
        for (int k = 0; k <= 8; k++) begin
            tick();
            set_idle();
            MemReqM   = (k <= 6);
            MemReadyM = (k == 6);
            @(negedge clk);
            check($sformatf("to%0d mem_fault", k), 32'(mem_fault), (k >= 5) ? 32'h1 : 32'h0);
            check($sformatf("to%0d mem_wait", k), 32'(mem_wait), (k >= 1 && k <= 6) ? 32'h1 : 32'h0);
        end
        check("to wide-timeout no fault", 32'(s_mem_fault), 32'h0);
        do_reset();
        @(negedge clk);
        check("to fault cleared", 32'(mem_fault), 32'h0);

        // Reset asserted mid-WAIT takes effect without a clock edge.
        tick(); MemReqM = 1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("rw in wait", 32'(mem_wait), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rw async mem_wait", 32'(mem_wait), 32'h0);
        check("rw flushes", 32'(flushes()), 32'h7);
        check("rw stalls", 32'(stalls()), 32'h0);
        tick(); MemReqM = 0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("rw run after", 32'(mem_wait), 32'h0);

        // Counter saturation on the 2-bit instance.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tick(); set_idle(); set_lw(5'd7);
        end
        for (int k = 0; k < 4; k++) begin
            tick(); set_idle(); PCSrcE = 1;
        end
        tick(); set_idle();
        @(negedge clk);
        check("sat stall wide", 32'(stall_count), 32'd5);
        check("sat stall narrow", 32'(s_stall_count), 32'd3);
        check("sat flush wide", 32'(flush_count), 32'd4);
        check("sat flush narrow", 32'(s_flush_count), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline control unit for the 5-stage core: drives stall/flush enables of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers, and selects EX-stage operand forwarding.
- Resolves load-use hazards, taken branch/jump redirects, and multi-cycle data-memory waits.
- The memory wait is sequenced by a small FSM with a timeout fault, plus saturating stall/flush performance counters.
- Sits beside the datapath. Inputs come from decode/execute/memory/writeback stage signals; outputs feed the stage registers' enable/flush pins and the EX operand muxes.

Parameters:
- COUNT_W, 16, width of the stall and flush performance counters.
- MEM_TIMEOUT, 64, number of consecutive wait cycles after which mem_fault sets.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- Rs1D, Rs2D  in  5  source registers of the instruction in D.
- Rs1E, Rs2E, RdE  in  5  source and destination registers in E.
- ResultSrcE  in  2  result select in E; 2'b01 marks a load.
- RegWriteE  in  1  E writes the register file.
- PCSrcE  in  1  taken branch or jump resolved in E.
- RdM, RdW  in  5  destination registers in M and W.
- RegWriteM, RegWriteW  in  1  M / W write the register file.
- MemReqM  in  1  M holds a load or store.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1  hold the PC / stage register.
- FlushD, FlushE, FlushW  out  1  load a bubble into that stage register.
- ForwardAE, ForwardBE  out  2  EX operand select: 00 register file, 01 from W, 10 from M.
- mem_wait  out  1  FSM is in WAIT.
- mem_fault  out  1  sticky timeout flag.
- stall_count, flush_count  out  COUNT_W  saturating performance counters.

Behaviour:
- Reset (async):
  - FSM enters RUN; counters and mem_fault go to 0.
  - While rst is high: FlushD=FlushE=FlushW=1, all Stall*=0, Forward*=00.
- Forwarding (combinational, any state):
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Else ForwardAE=01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Else ForwardAE=00. M has priority over W.
  - ForwardBE is identical, using Rs2E.
- Definitions:
  - lwStall = RegWriteE && ResultSrcE==01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
  - memStall = MemReqM && !MemReadyM.
- FSM has two states, RUN and WAIT:
  - RUN -> WAIT when memStall is 1.
  - WAIT -> RUN on the first cycle with MemReadyM=1.
  - mem_wait=1 exactly while in WAIT.
  - The freeze outputs are combinational on memStall, so the first miss cycle freezes with no extra latency.
- Priority 1, memStall=1 (either state):
  - StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
  - lwStall and PCSrcE are ignored that cycle. They remain valid and take effect on the release cycle.
- Priority 2, PCSrcE=1:
  - FlushD=1, FlushE=1, StallF=0 (the PC must load the target), StallD=0.
  - This applies even when lwStall=1: the flush wins.
- Priority 3, lwStall=1: StallF=StallD=1, FlushE=1.
- Otherwise every Stall* and Flush* output is 0. StallE, StallM and FlushW are asserted only under priority 1.
- Timeout:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches MEM_TIMEOUT, mem_fault sets and stays set until rst.
  - The wait itself continues.
- Counters:
  - stall_count increments on every cycle with StallF=1.
  - flush_count increments on every cycle with PCSrcE=1 and memStall=0.
  - Both saturate at all-ones and never wrap.
- Reset asserted mid-WAIT returns the FSM to RUN immediately. The memory side is responsible for dropping MemReqM.

Test Plan:
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Then RdM=0 -> ForwardAE=01. Then Rs1E=0, RdW=0 -> 00.
- Load-use: ResultSrcE=01, RegWriteE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; stall_count goes 0->1. With RdE=0 -> no stall.
- Branch during load-use: PCSrcE=1 with lwStall=1 -> FlushD=FlushE=1, StallF=0; flush_count increments by 1.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> all four stalls and FlushW=1 for 3 cycles; mem_wait=1 for cycles 2-4; release on cycle 4; stall_count +3.
- Timeout: MEM_TIMEOUT=4, memory not ready for 6 cycles -> mem_fault rises after 4 WAIT cycles and stays 1 after ready; cleared only by rst.
- Reset mid-WAIT and saturation: rst pulsed during WAIT -> mem_wait=0 asynchronously, Flush{D,E,W}=1 while rst high. With COUNT_W=2, 5 stall cycles -> stall_count=3.
